// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the AXI-Stream arbiter.
// rr_pick scans from ptr+1 upward with wrap over n requesters.
package axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
  } pick_t;

  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [3:0]         ptr,
    input int                 n
  );
    pick_t p;
    int    idx;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && !p.found && req[idx]) begin
        p.found = 1'b1;
        p.index = idx[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_picker.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
// Thin wrapper around the package search so it can be tested on its own.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] index
);

  pick_t      p;
  logic [3:0] pick_unused;

  always_comb begin
    p = rr_pick(MAX_REQ'(req), 4'(ptr), NUM_REQ);
  end

  assign found       = p.found;
  assign index       = p.index[ID_WIDTH-1:0];
  assign pick_unused = p.index;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink.
// Grant is locked from first beat through the accepted tlast beat.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_REQ-1:0]              s_axis_tvalid,
  input  logic [NUM_REQ-1:0]              s_axis_tlast,
  output logic [NUM_REQ-1:0]              s_axis_tready,
  input  logic                            m01_axis_tready,
  output logic [DATA_WIDTH-1:0]           m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m01_axis_tstrb,
  output logic                            m01_axis_tvalid,
  output logic                            m01_axis_tlast,
  output logic                            grant_valid,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic [15:0]                     pkt_count
);

  localparam int STRB_W = DATA_WIDTH / 8;

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                gv_q, gv_d;
  logic [15:0]         pkt_q, pkt_d;

  logic                found;
  logic [ID_WIDTH-1:0] winner;
  logic                active;
  logic                beat;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [STRB_W-1:0]     req_strb [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign req_strb[i] = s_axis_tstrb[i*STRB_W +: STRB_W];
  end

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req   (s_axis_tvalid),
    .ptr   (ptr_q),
    .found (found),
    .index (winner)
  );

  // Reset wins over a transfer in the same cycle.
  assign active = (state_q == STREAM) && !axis_areset;

  always_comb begin
    s_axis_tready   = '0;
    m01_axis_tdata  = '0;
    m01_axis_tstrb  = '0;
    m01_axis_tvalid = 1'b0;
    m01_axis_tlast  = 1'b0;
    if (active) begin
      m01_axis_tdata          = req_data[grant_q];
      m01_axis_tstrb          = req_strb[grant_q];
      m01_axis_tvalid         = s_axis_tvalid[grant_q];
      m01_axis_tlast          = s_axis_tlast[grant_q];
      s_axis_tready[grant_q]  = m01_axis_tready;
    end
  end

  assign beat = m01_axis_tvalid && m01_axis_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gv_d    = gv_q;
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          gv_d    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat && m01_axis_tlast) begin
          state_d = IDLE;
          gv_d    = 1'b0;
          ptr_d   = grant_q;
          pkt_d   = pkt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
    end
  end

  assign grant_valid = gv_q;
  assign grant_id    = grant_q;
  assign pkt_count   = pkt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-requester source queues, a beat
// scoreboard, a per-cycle vector table and hand-written corner sequences.
module tb_axis_rr_arbiter;

  logic         clk = 1'b0;
  logic         axis_areset;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tstrb;
  logic [3:0]   s_axis_tvalid;
  logic [3:0]   s_axis_tlast;
  logic [3:0]   s_axis_tready;
  logic         m01_axis_tready;
  logic [31:0]  m01_axis_tdata;
  logic [3:0]   m01_axis_tstrb;
  logic         m01_axis_tvalid;
  logic         m01_axis_tlast;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [15:0]  pkt_count;

  axis_rr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
    .axis_aclk       (clk),
    .axis_areset     (axis_areset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tstrb    (s_axis_tstrb),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m01_axis_tready (m01_axis_tready),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tstrb  (m01_axis_tstrb),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tlast  (m01_axis_tlast),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .pkt_count       (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } exp_t;

  typedef struct {
    logic        gv;
    logic [1:0]  id;
    logic        tv;
    logic [31:0] data;
    logic [15:0] pc;
  } vec_t;

  beat_t src_q [4][$];
  exp_t  sb [$];
  logic [3:0] pause = '0;
  logic [3:0] hs = '0;
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int i, input int n, input logic [31:0] base,
                      input int nexp);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'(k);
      b.strb = ~b.data[3:0];
      b.last = (k == n - 1);
      src_q[i].push_back(b);
      if (k < nexp) begin
        e.id   = 2'(i);
        e.data = b.data;
        e.strb = b.strb;
        e.last = b.last;
        sb.push_back(e);
      end
    end
  endtask

  // Sources hold a beat until the handshake seen at the previous negedge.
  task automatic driver();
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      #1;
      for (int i = 0; i < 4; i++) begin
        if (src_q[i].size() > 0 && !pause[i]) begin
          s_axis_tvalid[i]        = 1'b1;
          s_axis_tdata[i*32 +: 32] = src_q[i][0].data;
          s_axis_tstrb[i*4 +: 4]  = src_q[i][0].strb;
          s_axis_tlast[i]         = src_q[i][0].last;
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [3:0] allow;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      allow = grant_valid ? (4'b1 << grant_id) : 4'b0;
      chk("tready_mask", 32'(s_axis_tready & ~allow), 32'd0);
      if (m01_axis_tvalid && m01_axis_tready) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL beat_unexpected: got %h expected none at %0t",
                   m01_axis_tdata, $time);
        end else begin
          e = sb.pop_front();
          chk("beat_id", 32'(grant_id), 32'(e.id));
          chk("beat_data", m01_axis_tdata, e.data);
          chk("beat_strb", 32'(m01_axis_tstrb), 32'(e.strb));
          chk("beat_last", 32'(m01_axis_tlast), 32'(e.last));
        end
      end
    end
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic poll_sb(input int lim, input int max);
    int n = 0;
    while (sb.size() > lim && n < max) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("poll_sb", 32'(sb.size() <= lim), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    axis_areset     = 1'b1;
    m01_axis_tready = 1'b1;
    s_axis_tdata    = '0;
    s_axis_tstrb    = '0;
    s_axis_tvalid   = '0;
    s_axis_tlast    = '0;
    fork
      driver();
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_pc", 32'(pkt_count), 32'd0);
    chk("rst_tvalid", 32'(m01_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m01_axis_tlast), 32'd0);
    chk("rst_tdata", m01_axis_tdata, 32'd0);
    chk("rst_tstrb", 32'(m01_axis_tstrb), 32'd0);
    @(posedge clk);
    #1 axis_areset = 1'b0;

    // Single requester 2, 3-beat packet, back-to-back beats
    @(negedge clk);
    load(2, 3, 32'hA0, 3);
    @(negedge clk);
    chk("s1_arb_gv", 32'(grant_valid), 32'd0);
    chk("s1_arb_tv", 32'(m01_axis_tvalid), 32'd0);
    @(negedge clk);
    chk("s1_gv", 32'(grant_valid), 32'd1);
    chk("s1_id", 32'(grant_id), 32'd2);
    chk("s1_b0", 32'(m01_axis_tvalid), 32'd1);
    @(negedge clk);
    chk("s1_b1", 32'(m01_axis_tvalid), 32'd1);
    @(negedge clk);
    chk("s1_b2", 32'(m01_axis_tvalid), 32'd1);
    chk("s1_last", 32'(m01_axis_tlast), 32'd1);
    @(negedge clk);
    chk("s1_idle_gv", 32'(grant_valid), 32'd0);
    chk("s1_pc", 32'(pkt_count), 32'd1);
    chk("s1_drain", 32'(sb.size()), 32'd0);

    // Requester 1, 4 beats under a toggling downstream ready
    load(1, 4, 32'hB0, 4);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #2 m01_axis_tready = (k % 2 == 0);
      @(negedge clk);
      chk("s3_gv", 32'(grant_valid), 32'd1);
      chk("s3_id", 32'(grant_id), 32'd1);
      chk("s3_rdy", 32'(s_axis_tready[1]), 32'(m01_axis_tready));
    end
    @(posedge clk);
    #2 m01_axis_tready = 1'b1;
    chk("s3_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("s3_pc", 32'(pkt_count), 32'd2);

    // Requester 0 stalls mid-packet while requester 3 waits
    load(0, 4, 32'hD0, 4);
    poll_sb(3, 20);
    pause[0] = 1'b1;
    load(3, 1, 32'hE0, 1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s4_gap_tv", 32'(m01_axis_tvalid), 32'd0);
      chk("s4_gap_gv", 32'(grant_valid), 32'd1);
      chk("s4_gap_id", 32'(grant_id), 32'd0);
    end
    pause[0] = 1'b0;
    wait_empty(30);
    @(negedge clk);
    chk("s4_pc", 32'(pkt_count), 32'd4);

    @(posedge clk);
    #1 axis_areset = 1'b1;
    @(posedge clk);
    #1 axis_areset = 1'b0;

    // Per-cycle table: four single-beat packets plus a second from 0
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h0,   16'd0};
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 32'h100, 16'd0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0,   16'd1};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 32'h200, 16'd1};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h0,   16'd2};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 32'h300, 16'd2};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h0,   16'd3};
    tbl[7]  = '{1'b1, 2'd3, 1'b1, 32'h400, 16'd3};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h0,   16'd4};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 32'h101, 16'd4};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h0,   16'd5};
    @(negedge clk);
    load(0, 1, 32'h100, 1);
    load(1, 1, 32'h200, 1);
    load(2, 1, 32'h300, 1);
    load(3, 1, 32'h400, 1);
    load(0, 1, 32'h101, 1);
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      chk($sformatf("t%0d_gv", r), 32'(grant_valid), 32'(tbl[r].gv));
      chk($sformatf("t%0d_id", r), 32'(grant_id), 32'(tbl[r].id));
      chk($sformatf("t%0d_tv", r), 32'(m01_axis_tvalid), 32'(tbl[r].tv));
      chk($sformatf("t%0d_pc", r), 32'(pkt_count), 32'(tbl[r].pc));
      if (tbl[r].tv)
        chk($sformatf("t%0d_data", r), m01_axis_tdata, tbl[r].data);
    end

    // Reset after beat 2 of a 5-beat packet from requester 0
    load(0, 5, 32'hF0, 2);
    poll_sb(0, 20);
    axis_areset = 1'b1;
    @(negedge clk);
    chk("s5_rst_tv", 32'(m01_axis_tvalid), 32'd0);
    chk("s5_rst_rdy", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #3 src_q[0].delete();
    @(negedge clk);
    chk("s5_gv", 32'(grant_valid), 32'd0);
    chk("s5_id", 32'(grant_id), 32'd0);
    chk("s5_pc", 32'(pkt_count), 32'd0);
    chk("s5_tlast", 32'(m01_axis_tlast), 32'd0);
    chk("s5_tdata", m01_axis_tdata, 32'd0);
    @(posedge clk);
    #3 axis_areset = 1'b0;
    @(negedge clk);
    load(0, 1, 32'h500, 1);
    load(1, 1, 32'h510, 1);
    @(negedge clk);
    @(negedge clk);
    chk("s5_first_gv", 32'(grant_valid), 32'd1);
    chk("s5_first_id", 32'(grant_id), 32'd0);
    wait_empty(20);

    // Packet counter wraps from 0xFFFF to 0
    @(negedge clk);
    force dut.pkt_q = 16'hFFFE;
    #1 release dut.pkt_q;
    load(2, 1, 32'h600, 1);
    wait_empty(20);
    @(negedge clk);
    chk("s6_pc_ffff", 32'(pkt_count), 32'hFFFF);
    load(3, 1, 32'h700, 1);
    wait_empty(20);
    @(negedge clk);
    chk("s6_pc_wrap", 32'(pkt_count), 32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
